// File: rtl/shmem_bank_arbiter_pkg.sv
// Shared-memory geometry for the bank arbiter: 16 low-order-interleaved banks of 256 x 8-bit rows.
package shmem_pkg;
  localparam int N_BANKS = 16;
  localparam int BANK_W  = 4;
  localparam int ROW_W   = 8;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = ROW_W + BANK_W;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[BANK_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:BANK_W];
  endfunction
endpackage

// File: rtl/shmem_bank_arbiter_if.sv
// Requester-side and bank-side buses of the arbiter; master = cores plus banks, slave = arbiter.
interface shmem_bank_arbiter_if #(parameter int N_REQ = 4) ();
  import shmem_pkg::*;

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_write;
  logic [N_REQ*ADDR_W-1:0]   req_addr;
  logic [N_REQ*DATA_W-1:0]   req_wdata;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ*DATA_W-1:0]   rsp_rdata;
  logic [N_BANKS-1:0]        bank_read;
  logic [N_BANKS-1:0]        bank_write;
  logic [N_BANKS*ROW_W-1:0]  bank_addr;
  logic [N_BANKS*DATA_W-1:0] bank_wdata;
  logic [N_BANKS*DATA_W-1:0] bank_rdata;
  logic [N_BANKS-1:0]        bank_finish;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, bank_rdata, bank_finish,
    input  req_ready, rsp_valid, rsp_rdata, bank_read, bank_write, bank_addr, bank_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, bank_rdata, bank_finish,
    output req_ready, rsp_valid, rsp_rdata, bank_read, bank_write, bank_addr, bank_wdata
  );
endinterface

// File: rtl/shmem_bank_arbiter_rr.sv
// Rotating-priority arbiter for one bank: grants the first request at or after the pointer.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);
  logic [IDX_W-1:0] ptr_reg;
  int               cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = int'(ptr_reg) + k;
      if (cand_idx >= N_REQ) cand_idx = cand_idx - N_REQ;
      if (!grant_any && req[cand_idx]) begin
        grant_any        = 1'b1;
        grant[cand_idx]  = 1'b1;
        grant_idx        = IDX_W'(cand_idx);
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      ptr_reg <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/shmem_bank_arbiter.sv
// Crossbar between N_REQ cores and 16 shared-memory banks with per-bank rotating priority,
// fixed two-cycle read return and a saturating bank-conflict counter.
module shmem_bank_arbiter
  import shmem_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  shmem_bank_arbiter_if.slave   bus,
  output logic [15:0]           stat_conflict
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [BANK_W-1:0]                  req_bank [N_REQ];
  logic [ROW_W-1:0]                   req_row  [N_REQ];
  logic [N_BANKS-1:0][N_REQ-1:0]      cand;
  logic [N_BANKS-1:0][N_REQ-1:0]      grant;
  logic [N_BANKS-1:0][IDX_W-1:0]      win_idx;
  logic [N_BANKS-1:0]                 win_any;
  logic [N_REQ-1:0]                   ready_or;

  logic [N_BANKS-1:0]                 issued_reg;
  logic [N_BANKS-1:0]                 rd_reg;
  logic [N_BANKS-1:0][IDX_W-1:0]      id_reg;
  logic [N_REQ-1:0]                   rsp_valid_reg, rsp_valid_next;
  logic [N_REQ*DATA_W-1:0]            rsp_rdata_reg, rsp_rdata_next;
  logic [15:0]                        stat_reg, stat_next;
  logic [4:0]                         n_conf;
  logic [16:0]                        stat_sum;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign req_bank[gi] = bank_of(bus.req_addr[gi*ADDR_W +: ADDR_W]);
      assign req_row[gi]  = row_of(bus.req_addr[gi*ADDR_W +: ADDR_W]);
    end

    for (gi = 0; gi < N_BANKS; gi++) begin : g_bank
      // Candidates are masked during reset so nothing reaches a bank.
      for (gj = 0; gj < N_REQ; gj++) begin : g_cand
        assign cand[gi][gj] = ~reset & bus.req_valid[gj] & (req_bank[gj] == BANK_W'(gi));
      end

      rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (cand[gi]),
        .grant     (grant[gi]),
        .grant_idx (win_idx[gi]),
        .grant_any (win_any[gi])
      );

      assign bus.bank_read[gi]  = win_any[gi] & ~bus.req_write[win_idx[gi]];
      assign bus.bank_write[gi] = win_any[gi] &  bus.req_write[win_idx[gi]];
      assign bus.bank_addr[gi*ROW_W +: ROW_W] = win_any[gi] ? req_row[win_idx[gi]] : '0;
      assign bus.bank_wdata[gi*DATA_W +: DATA_W] = bus.bank_write[gi]
                                                 ? bus.req_wdata[win_idx[gi]*DATA_W +: DATA_W]
                                                 : '0;
    end
  endgenerate

  always_comb begin
    ready_or = '0;
    n_conf   = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      ready_or = ready_or | grant[b];
      if ($countones(cand[b]) > 1) n_conf = n_conf + 5'd1;
    end
  end

  assign bus.req_ready = ready_or;

  // Each requester wins at most one bank per cycle, so at most one bank matches its id.
  always_comb begin
    rsp_valid_next = '0;
    rsp_rdata_next = rsp_rdata_reg;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rd_reg[b] && id_reg[b] == IDX_W'(i)) begin
          rsp_valid_next[i]                  = 1'b1;
          rsp_rdata_next[i*DATA_W +: DATA_W] = bus.bank_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign stat_sum  = {1'b0, stat_reg} + {12'd0, n_conf};
  assign stat_next = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_reg    <= '0;
      rd_reg        <= '0;
      id_reg        <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      stat_reg      <= '0;
    end else begin
      issued_reg    <= win_any;
      rd_reg        <= bus.bank_read;
      id_reg        <= win_idx;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      stat_reg      <= stat_next;
    end
  end

  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_rdata  = rsp_rdata_reg;
  assign stat_conflict  = stat_reg;

  // Every bank must report completion exactly one cycle after it was issued a command.
  a_bank_finish: assert property (@(posedge clock) disable iff (reset) bus.bank_finish == issued_reg);
endmodule
